ram_arbiter: RTL and testbench

- Shares one dual-port RAM between NUM_REQ requesters. The RAM has an independent write port and read port.
- Two independent round-robin arbiters are used: one grants at most one write per cycle, the other at most one read per cycle.
- Granted commands are registered and driven onto the RAM port. Read data is returned with a one-hot rvalid to the requester that issued the read.
- Sits between the requester agents and the ram instance in the RAM subsystem.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/ram_arbiter.sv | 102 ++++++++++
 tb/tb_ram_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants, types and helpers for the dual-port RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_REQ        = 8;
  localparam int MAX_IDX_W      = 3;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

  // OR of the indices of all set bits; exact for a one-hot or all-zero input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
// gnt_idx reports the candidate even when hold is set, so callers can inspect it.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             hold,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     cand;

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    logic [IDX_W-1:0] k;
    cand = '0;
    k    = '0;
    for (int i = N; i >= 1; i--) begin
      k = IDX_W'((int'(ptr) + i) % N);
      if (req[k]) begin
        cand    = '0;
        cand[k] = 1'b1;
      end
    end
  end

  assign gnt_idx   = IDX_W'(onehot_to_idx(MAX_REQ'(cand)));
  assign gnt_valid = (|cand) & ~hold & ~rst;
  assign gnt       = gnt_valid ? cand : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(N - 1);
    end else if (gnt_valid) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one dual-port RAM between NUM_REQ requesters with independent
// round-robin write and read arbitration and a 2-cycle read return path.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NUM_REQ    = NUM_REQ_DEF,
  parameter  int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          ram_wr_enb,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          ram_rd_enb,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_a [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wr_addr_a[g] = wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_a[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr_a[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_go, rd_go;
  logic             collision;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (wr_req),
    .hold      (1'b0),
    .gnt       (wr_gnt),
    .gnt_idx   (wr_idx),
    .gnt_valid (wr_go)
  );

  // A read that would race a same-cycle write to its address waits one cycle
  // so it is issued after the write and returns the new data.
  assign collision = wr_go & (|rd_req) & (rd_addr_a[rd_idx] == wr_addr_a[wr_idx]);

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (rd_req),
    .hold      (collision),
    .gnt       (rd_gnt),
    .gnt_idx   (rd_idx),
    .gnt_valid (rd_go)
  );

  logic [IDX_W-1:0] rd_idx_q1, rd_idx_q2;
  logic             rd_vld_q1, rd_vld_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr_enb  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_enb  <= 1'b0;
      ram_rd_addr <= '0;
      rd_vld_q1   <= 1'b0;
      rd_vld_q2   <= 1'b0;
      rd_idx_q1   <= '0;
      rd_idx_q2   <= '0;
    end else begin
      ram_wr_enb <= wr_go;
      if (wr_go) begin
        ram_wr_addr <= wr_addr_a[wr_idx];
        ram_wr_data <= wr_data_a[wr_idx];
      end
      ram_rd_enb <= rd_go;
      if (rd_go) begin
        ram_rd_addr <= rd_addr_a[rd_idx];
      end
      rd_vld_q1 <= rd_go;
      rd_idx_q1 <= rd_idx;
      rd_vld_q2 <= rd_vld_q1;
      rd_idx_q2 <= rd_idx_q1;
    end
  end

  assign rd_valid = rd_vld_q2 ? (NUM_REQ'(1) << rd_idx_q2) : '0;
  assign rd_data  = ram_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed-vector bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;

  localparam int NR = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
  logic [NR*AW-1:0] wr_addr, rd_addr;
  logic [NR*DW-1:0] wr_data;
  logic [DW-1:0]    rd_data, ram_wr_data, ram_rd_data;
  logic             ram_wr_enb, ram_rd_enb;
  logic [AW-1:0]    ram_wr_addr, ram_rd_addr;

  int vec  = 0;
  int errs = 0;

  logic [DW-1:0] mem [16] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
                              8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_enb === 1'b1) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_enb === 1'b1) ram_rd_data <= mem[ram_rd_addr];
  end

  ram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .ram_wr_enb  (ram_wr_enb),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_enb  (ram_rd_enb),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 4'hF; rd_req = 4'hF;
    tick(); tick();
    vec++; if (wr_gnt !== 4'b0000) begin errs++; $display("FAIL rst_wr_gnt got=%b exp=0000", wr_gnt); end
    vec++; if (rd_gnt !== 4'b0000) begin errs++; $display("FAIL rst_rd_gnt got=%b exp=0000", rd_gnt); end
    vec++; if ({ram_wr_enb, ram_rd_enb} !== 2'b00) begin errs++; $display("FAIL rst_enb got=%b exp=00", {ram_wr_enb, ram_rd_enb}); end
    vec++; if ({ram_wr_addr, ram_rd_addr, ram_wr_data} !== 16'h0000) begin errs++; $display("FAIL rst_cmd got=%h exp=0000", {ram_wr_addr, ram_rd_addr, ram_wr_data}); end
    vec++; if (rd_valid !== 4'b0000) begin errs++; $display("FAIL rst_rd_valid got=%b exp=0000", rd_valid); end
    wr_req = '0; rd_req = '0; rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    set_wr(2, 4'd3, 8'hA5); wr_req = 4'b0100; #1;
    vec++; if (wr_gnt !== 4'b0100) begin errs++; $display("FAIL single_wr_gnt got=%b exp=0100", wr_gnt); end
    tick(); wr_req = '0; #1;
    vec++; if ({ram_wr_enb, ram_wr_addr, ram_wr_data} !== {1'b1, 4'd3, 8'hA5})
      begin errs++; $display("FAIL single_wr_cmd got=%b/%h/%h exp=1/3/a5", ram_wr_enb, ram_wr_addr, ram_wr_data); end
    tick();
    vec++; if (ram_wr_enb !== 1'b0) begin errs++; $display("FAIL single_wr_idle got=%b exp=0", ram_wr_enb); end
  endtask

  task automatic test_rr_writes();
    logic [NR-1:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NR; i++) set_wr(i, AW'(i), DW'(8'h10 + i));
    wr_req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = 4'b0001 << (c % 4);
      vec++; if (wr_gnt !== exp_g) begin errs++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, wr_gnt, exp_g); end
      tick();
      vec++; if ({ram_wr_enb, ram_wr_addr} !== {1'b1, AW'(c % 4)})
        begin errs++; $display("FAIL rr_cmd[%0d] got=%b/%h exp=1/%h", c, ram_wr_enb, ram_wr_addr, c % 4); end
    end
    wr_req = '0;
    tick();
  endtask

  task automatic test_write_then_read();
    set_wr(0, 4'd5, 8'h3C); wr_req = 4'b0001; #1;
    vec++; if (wr_gnt !== 4'b0001) begin errs++; $display("FAIL wtr_wr_gnt got=%b exp=0001", wr_gnt); end
    tick(); wr_req = '0;
    tick();
    set_rd(1, 4'd5); rd_req = 4'b0010; #1;
    vec++; if (rd_gnt !== 4'b0010) begin errs++; $display("FAIL wtr_rd_gnt got=%b exp=0010", rd_gnt); end
    tick(); rd_req = '0; #1;
    vec++; if ({rd_valid, ram_rd_enb, ram_rd_addr} !== {4'b0000, 1'b1, 4'd5})
      begin errs++; $display("FAIL wtr_n1 got=%b/%b/%h exp=0000/1/5", rd_valid, ram_rd_enb, ram_rd_addr); end
    tick();
    vec++; if (rd_valid !== 4'b0010) begin errs++; $display("FAIL wtr_rd_valid got=%b exp=0010", rd_valid); end
    vec++; if (rd_data !== 8'h3C) begin errs++; $display("FAIL wtr_rd_data got=%h exp=3c", rd_data); end
    tick();
    vec++; if (rd_valid !== 4'b0000) begin errs++; $display("FAIL wtr_rd_valid_end got=%b exp=0000", rd_valid); end
  endtask

  task automatic test_collision();
    set_wr(0, 4'd7, 8'h11); wr_req = 4'b0001;
    set_rd(3, 4'd7); set_rd(1, 4'd4); rd_req = 4'b1010; #1;
    vec++; if (wr_gnt !== 4'b0001) begin errs++; $display("FAIL col_wr_gnt got=%b exp=0001", wr_gnt); end
    vec++; if (rd_gnt !== 4'b0000) begin errs++; $display("FAIL col_rd_stall got=%b exp=0000", rd_gnt); end
    tick(); wr_req = '0; #1;
    vec++; if (rd_gnt !== 4'b1000) begin errs++; $display("FAIL col_rd_gnt got=%b exp=1000", rd_gnt); end
    vec++; if ({ram_wr_enb, ram_wr_addr, ram_wr_data} !== {1'b1, 4'd7, 8'h11})
      begin errs++; $display("FAIL col_wr_cmd got=%b/%h/%h exp=1/7/11", ram_wr_enb, ram_wr_addr, ram_wr_data); end
    tick(); rd_req = 4'b0010; #1;
    vec++; if (rd_gnt !== 4'b0010) begin errs++; $display("FAIL col_rd_gnt2 got=%b exp=0010", rd_gnt); end
    vec++; if ({ram_rd_enb, ram_rd_addr} !== {1'b1, 4'd7}) begin errs++; $display("FAIL col_rd_cmd got=%b/%h exp=1/7", ram_rd_enb, ram_rd_addr); end
    tick(); rd_req = '0; #1;
    vec++; if ({rd_valid, rd_data} !== {4'b1000, 8'h11}) begin errs++; $display("FAIL col_ret3 got=%b/%h exp=1000/11", rd_valid, rd_data); end
    tick();
    vec++; if ({rd_valid, rd_data} !== {4'b0010, 8'h84}) begin errs++; $display("FAIL col_ret1 got=%b/%h exp=0010/84", rd_valid, rd_data); end
    tick();
  endtask

  task automatic test_parallel();
    set_wr(0, 4'd2, 8'h5A); wr_req = 4'b0001;
    set_rd(1, 4'd9); rd_req = 4'b0010; #1;
    vec++; if ({wr_gnt, rd_gnt} !== {4'b0001, 4'b0010}) begin errs++; $display("FAIL par_gnt got=%b/%b exp=0001/0010", wr_gnt, rd_gnt); end
    tick(); wr_req = '0; rd_req = '0; #1;
    vec++; if ({ram_wr_enb, ram_wr_addr, ram_rd_enb, ram_rd_addr} !== {1'b1, 4'd2, 1'b1, 4'd9})
      begin errs++; $display("FAIL par_cmd got=%b/%h/%b/%h exp=1/2/1/9", ram_wr_enb, ram_wr_addr, ram_rd_enb, ram_rd_addr); end
    tick();
    vec++; if ({rd_valid, rd_data} !== {4'b0010, 8'h89}) begin errs++; $display("FAIL par_ret got=%b/%h exp=0010/89", rd_valid, rd_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_wr(1, 4'd10, 8'h21); set_wr(2, 4'd11, 8'h22);
    wr_req = 4'b0100; #1;
    vec++; if (wr_gnt !== 4'b0100) begin errs++; $display("FAIL b2b_first got=%b exp=0100", wr_gnt); end
    tick(); #1;
    vec++; if (wr_gnt !== 4'b0100) begin errs++; $display("FAIL b2b_repeat got=%b exp=0100", wr_gnt); end
    tick(); wr_req = 4'b0110; #1;
    vec++; if (wr_gnt !== 4'b0010) begin errs++; $display("FAIL b2b_rotate got=%b exp=0010", wr_gnt); end
    tick(); wr_req = '0; #1;
    vec++; if ({wr_gnt, rd_gnt} !== 8'h00) begin errs++; $display("FAIL idle_gnt got=%b/%b exp=0000/0000", wr_gnt, rd_gnt); end
    tick();
    vec++; if ({ram_wr_enb, ram_rd_enb} !== 2'b00) begin errs++; $display("FAIL idle_enb got=%b exp=00", {ram_wr_enb, ram_rd_enb}); end
    wr_req = 4'b0101; #1;
    vec++; if (wr_gnt !== 4'b0100) begin errs++; $display("FAIL idle_ptr_hold got=%b exp=0100", wr_gnt); end
    tick(); wr_req = '0;
    tick();
  endtask

  task automatic test_reset_inflight();
    set_rd(2, 4'd0); rd_req = 4'b0100; #1;
    vec++; if (rd_gnt !== 4'b0100) begin errs++; $display("FAIL rsti_rd_gnt got=%b exp=0100", rd_gnt); end
    tick(); rd_req = '0; rst = 1'b1; #1;
    vec++; if (rd_valid !== 4'b0000) begin errs++; $display("FAIL rsti_v1 got=%b exp=0000", rd_valid); end
    tick();
    vec++; if ({rd_valid, ram_rd_enb} !== 5'b00000) begin errs++; $display("FAIL rsti_v2 got=%b/%b exp=0000/0", rd_valid, ram_rd_enb); end
    rst = 1'b0;
    tick();
    vec++; if (rd_valid !== 4'b0000) begin errs++; $display("FAIL rsti_v3 got=%b exp=0000", rd_valid); end
    set_rd(0, 4'd1); set_rd(1, 4'd2); rd_req = 4'b0011;
    set_wr(0, 4'd8, 8'h31); set_wr(1, 4'd9, 8'h32); wr_req = 4'b0011; #1;
    vec++; if ({wr_gnt, rd_gnt} !== {4'b0001, 4'b0001}) begin errs++; $display("FAIL rsti_prio got=%b/%b exp=0001/0001", wr_gnt, rd_gnt); end
    tick(); wr_req = '0; rd_req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_single_write();
    test_rr_writes();
    test_write_then_read();
    test_collision();
    test_parallel();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
